// File: rtl/instruction_fetch_unit_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch unit.
//   fetch_state_t        - fetch FSM states
//   PC_INCREMENT         - byte distance between sequential instructions
//   DEFAULT_RESET_PC     - default reset fetch address
//   DEFAULT_ADDR_WIDTH   - default PC/address width
//   DEFAULT_DATA_WIDTH   - default instruction width
package ifetch_pkg;
  localparam int          DEFAULT_ADDR_WIDTH = 32;
  localparam int          DEFAULT_DATA_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned PC_INCREMENT       = 4;

  // FETCH   : request outstanding at pc, result is wanted
  // HOLD    : a word came back while decode was stalled; no request
  // DISCARD : request at the old pc still outstanding, result is dropped
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// if_id_register: IF/ID pipeline register bank.
//   clk, rst          - clock, async active-high reset
//   load              - capture instr/pc/pc_plus4 and mark valid
//   clear             - drop the valid bit (wins over load); payload kept
//   instr_in, pc_in, pc_plus4_in - captured payload
//   valid, instr, pc, pc_plus4   - registered outputs
module if_id_register #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [ADDR_WIDTH-1:0] pc_plus4_in,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4
);
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage front end.
//   clk, reset                 - clock, async active-high reset
//   stall                      - decode cannot take IF/ID this cycle
//   redirect_valid/redirect_pc - restart fetch at redirect_pc (word aligned)
//   imem_req/imem_addr         - instruction memory request, held until ready
//   imem_ready/imem_rdata      - completes the request with the fetched word
//   if_valid/if_instr/if_pc/if_pc_plus4 - IF/ID register to decode
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_plus4
);
  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INCREMENT);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;

  logic                  load;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] redir_pc;
  logic                  ifid_load, ifid_clear;
  logic [DATA_WIDTH-1:0] ifid_instr;
  logic [ADDR_WIDTH-1:0] ifid_pc, ifid_pc_plus4;
  logic                  unused_redirect_lsb;

  assign load      = !if_valid || !stall;
  assign pc_plus4  = pc_q + INC;
  assign redir_pc  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Gated with reset directly so the request drops the instant reset rises.
  assign imem_req  = !reset && (state_q != HOLD);
  assign imem_addr = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    pending_pc_d  = pending_pc_q;
    ifid_load     = 1'b0;
    ifid_clear    = 1'b0;
    ifid_instr    = imem_rdata;
    ifid_pc       = pc_q;
    ifid_pc_plus4 = pc_plus4;
    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (redirect_valid) begin
            pc_d       = redir_pc;
            ifid_clear = 1'b1;
          end else if (load) begin
            ifid_load = 1'b1;
            pc_d      = pc_plus4;
          end else begin
            // Park the word; the memory is free again and decode is busy.
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            pc_d         = pc_plus4;
            state_d      = HOLD;
          end
        end else if (redirect_valid) begin
          // Access can't be cancelled: keep the address stable, drop the result.
          pending_pc_d = redir_pc;
          ifid_clear   = 1'b1;
          state_d      = DISCARD;
        end else if (load) begin
          ifid_clear = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d       = redir_pc;
          ifid_clear = 1'b1;
          state_d    = FETCH;
        end else if (load) begin
          ifid_load     = 1'b1;
          ifid_instr    = hold_instr_q;
          ifid_pc       = hold_pc_q;
          ifid_pc_plus4 = hold_pc_q + INC;
          state_d       = FETCH;
        end
      end
      DISCARD: begin
        ifid_clear = 1'b1;
        if (redirect_valid) pending_pc_d = redir_pc;
        if (imem_ready) begin
          pc_d    = redirect_valid ? redir_pc : pending_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  if_id_register #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk        (clk),
    .rst        (reset),
    .load       (ifid_load),
    .clear      (ifid_clear),
    .instr_in   (ifid_instr),
    .pc_in      (ifid_pc),
    .pc_plus4_in(ifid_pc_plus4),
    .valid      (if_valid),
    .instr      (if_instr),
    .pc         (if_pc),
    .pc_plus4   (if_pc_plus4)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Memory: the word at address A is A + 0x1000; each access takes lat wait cycles.
  int wait_cnt = 0;
  int lat      = 0;
  bit rand_lat = 1'b0;

  // Reference model: what decode should see, kept as plain values plus a
  // queue for a word that came back while decode was busy.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } word_t;
  word_t       held[$];
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr, m_ifpc, m_pc4;
  bit          m_stale;
  logic [31:0] m_target;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    held.delete();
    m_pc = 32'h0; m_valid = 1'b0; m_instr = 0; m_ifpc = 0; m_pc4 = 0;
    m_stale = 1'b0; m_target = 0;
  endtask

  task automatic deliver(input logic [31:0] instr, input logic [31:0] pc);
    m_valid = 1'b1; m_instr = instr; m_ifpc = pc; m_pc4 = pc + 32'd4;
  endtask

  task automatic model_step(input bit st, input bit rv, input logic [31:0] rp, input bit rdy);
    logic [31:0] rpm;
    bit ld;
    rpm = {rp[31:2], 2'b00};
    ld  = !m_valid || !st;
    if (held.size() != 0) begin
      if (rv) begin held.delete(); m_pc = rpm; m_valid = 1'b0; end
      else if (ld) begin deliver(held[0].instr, held[0].pc); held.delete(); end
    end else if (m_stale) begin
      m_valid = 1'b0;
      if (rv) m_target = rpm;
      if (rdy) begin m_pc = m_target; m_stale = 1'b0; end
    end else if (rdy) begin
      if (rv) begin m_pc = rpm; m_valid = 1'b0; end
      else if (ld) begin deliver(m_pc + 32'h1000, m_pc); m_pc = m_pc + 32'd4; end
      else begin held.push_back('{m_pc + 32'h1000, m_pc}); m_pc = m_pc + 32'd4; end
    end else if (rv) begin
      m_stale = 1'b1; m_target = rpm; m_valid = 1'b0;
    end else if (ld) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, held.size() == 0});
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", if_pc, m_ifpc);
      chk("if_pc_plus4", if_pc_plus4, m_pc4);
    end
  endtask

  // Called at a negedge: apply inputs, advance model, clock once, compare.
  task automatic step(input bit st, input bit rv, input logic [31:0] rp);
    bit rdy;
    stall = st; redirect_valid = rv; redirect_pc = rp;
    rdy = (imem_req === 1'b1) && (wait_cnt >= lat);
    imem_ready = rdy;
    imem_rdata = imem_addr + 32'h1000;
    model_step(st, rv, rp, rdy);
    if (imem_req === 1'b1) begin
      if (rdy) begin
        wait_cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else wait_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    reset = 1'b1; stall = 0; redirect_valid = 0; redirect_pc = 0;
    imem_ready = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc_plus4, 32'd0);
    reset = 1'b0;
    #1 compare_all();

    // Single-cycle memory, streaming
    lat = 0;
    step(0, 0, 0);
    chk("s_pc0", if_pc, 32'h0); chk("s_instr0", if_instr, 32'h1000); chk("s_pc4_0", if_pc_plus4, 32'h4);
    step(0, 0, 0);
    chk("s_pc1", if_pc, 32'h4); chk("s_instr1", if_instr, 32'h1004);
    // Stall three cycles: word at 8 is parked, request drops
    step(1, 0, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0); chk("hold_pc", if_pc, 32'h4);
    step(1, 0, 0); step(1, 0, 0);
    chk("hold_frozen", if_pc, 32'h4);
    step(0, 0, 0);
    chk("hold_out_pc", if_pc, 32'h8); chk("hold_out_instr", if_instr, 32'h1008);
    step(0, 0, 0);
    chk("resume_pc", if_pc, 32'hC);

    // 3-cycle memory, redirect in first wait cycle
    lat = 3;
    step(0, 1, 32'h40);
    repeat (2) begin
      step(0, 0, 0);
      chk("disc_addr", imem_addr, 32'h10); chk("disc_valid", {31'd0, if_valid}, 32'd0);
    end
    step(0, 0, 0);
    chk("redir_addr", imem_addr, 32'h40);
    // Two redirects while discarding: the latest wins
    step(0, 1, 32'h80); step(0, 1, 32'hC0); step(0, 0, 0); step(0, 0, 0);
    chk("latest_redir", imem_addr, 32'hC0);
    repeat (4) step(0, 0, 0);
    chk("c0_valid", {31'd0, if_valid}, 32'd1); chk("c0_pc", if_pc, 32'hC0);

    // Unaligned redirect and PC wrap
    lat = 0;
    step(0, 1, 32'h43);
    chk("align_addr", imem_addr, 32'h40);
    step(0, 1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC); chk("wrap_pc4", if_pc_plus4, 32'h0);
    step(0, 0, 0);
    chk("wrap_next", if_pc, 32'h0);

    // Random traffic against the model
    rand_lat = 1'b1;
    lat = $urandom_range(0, 3);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom);

    // Reset in the middle of an outstanding access
    rand_lat = 1'b0;
    for (int i = 0; i < 10 && !(imem_req === 1'b1 && wait_cnt < 3); i++) step(0, 0, 0);
    lat = 3;
    chk("mid_req_before", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    wait_cnt = 0; lat = 0;
    #1 compare_all();
    chk("restart_addr", imem_addr, 32'h0);
    step(0, 0, 0);
    chk("restart_pc", if_pc, 32'h0); chk("restart_valid", {31'd0, if_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
